// File: rtl/tcp_pkg.sv
// Shared TCP transmit definitions: header layout, flag values, segment-type
// and transmitter-state enums, and a helper that selects one header byte.
package tcp_pkg;

    localparam int unsigned TCP_HDR_BYTES = 13;
    localparam int unsigned TCP_HDR_W     = TCP_HDR_BYTES * 8;
    localparam int unsigned TCP_IDX_W     = 4;

    localparam logic [TCP_IDX_W-1:0] TCP_LAST_IDX = TCP_IDX_W'(TCP_HDR_BYTES - 1);

    localparam logic [7:0] TCP_FLAG_SYN    = 8'h02;
    localparam logic [7:0] TCP_FLAG_ACK    = 8'h10;
    localparam logic [7:0] TCP_FLAG_SYNACK = TCP_FLAG_SYN | TCP_FLAG_ACK;

    typedef enum logic [1:0] {
        SEG_SYN,
        SEG_SYNACK,
        SEG_ACK
    } seg_type_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_ACK
    } tx_state_e;

    // Header as sent on the wire, MSB (byte 0) first.
    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [31:0] seq;
        logic [31:0] ack;
        logic [7:0]  flags;
    } tcp_hdr_t;

    function automatic logic [7:0] seg_flags(seg_type_e t);
        logic [7:0] f;
        case (t)
            SEG_SYN:    f = TCP_FLAG_SYN;
            SEG_SYNACK: f = TCP_FLAG_SYNACK;
            SEG_ACK:    f = TCP_FLAG_ACK;
            default:    f = 8'h00;
        endcase
        return f;
    endfunction

    // Byte idx of the header, byte 0 being the most significant.
    function automatic logic [7:0] hdr_byte(tcp_hdr_t hdr, logic [TCP_IDX_W-1:0] idx);
        logic [TCP_HDR_W-1:0] sh;
        sh = TCP_HDR_W'(hdr) << {idx, 3'b000};
        return sh[TCP_HDR_W-1 -: 8];
    endfunction

endpackage

// File: rtl/tcp_seg_tx_if.sv
// Request/stream bundle between the handshake FSM, tcp_seg_tx and the
// downstream byte sink.
//   send_syn/send_synack/send_ack : one-cycle requests
//   rx_seq                        : peer sequence number
//   ack_in                        : peer acknowledged our SYN / SYN-ACK
//   tx_data/tx_valid/tx_last      : byte stream, tx_ready from the sink
//   busy/timeout/seq_num          : status
// slave = transmitter side, master = FSM / sink side.
interface tcp_seg_tx_if;

    logic        send_syn;
    logic        send_synack;
    logic        send_ack;
    logic [31:0] rx_seq;
    logic        ack_in;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic        busy;
    logic        timeout;
    logic [31:0] seq_num;

    modport slave (
        input  send_syn, send_synack, send_ack, rx_seq, ack_in, tx_ready,
        output tx_data, tx_valid, tx_last, busy, timeout, seq_num
    );

    modport master (
        output send_syn, send_synack, send_ack, rx_seq, ack_in, tx_ready,
        input  tx_data, tx_valid, tx_last, busy, timeout, seq_num
    );

endinterface

// File: rtl/tcp_retx_timer.sv
// Retransmission timer: counts cycles while i_run is high and tracks how many
// retransmissions have been issued since the last new request.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_run               : transmitter is waiting for an ack
//   i_retry_clr         : new request accepted
//   i_retry_inc         : retransmission issued
//   o_expire_c          : counter at RTO_CYCLES-1 this cycle
//   o_exhausted_c       : MAX_RETRY retransmissions already issued
module tcp_retx_timer #(
    parameter int unsigned RTO_CYCLES = 64,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_run,
    input  logic i_retry_clr,
    input  logic i_retry_inc,
    output logic o_expire_c,
    output logic o_exhausted_c
);

    localparam int unsigned CNT_W = (RTO_CYCLES > 1) ? $clog2(RTO_CYCLES) : 1;
    localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic [RTY_W-1:0] r_retry;

    assign o_expire_c    = i_run && (r_cnt == CNT_W'(RTO_CYCLES - 1));
    assign o_exhausted_c = (r_retry == RTY_W'(MAX_RETRY));

    // Cycle counter restarts from 0 on every entry into the wait.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_run || o_expire_c) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_retry_clr) begin
            r_retry <= '0;
        end else if (i_retry_inc) begin
            r_retry <= r_retry + RTY_W'(1);
        end
    end

endmodule

// File: rtl/tcp_seg_tx.sv
// Serializes SYN / SYN-ACK / ACK requests into 13-byte header segments on a
// byte-wide valid/ready stream and owns the local sequence number.
//   i_clk, i_rst : clock, synchronous active-high reset
//   io_seg       : request inputs, byte stream and status (tcp_seg_tx_if.slave)
// Build option TCP_TX_RETX_EN: when defined, unacknowledged SYN / SYN-ACK
// segments are resent every RTO_CYCLES up to MAX_RETRY times, then timeout
// pulses. When undefined, WAIT_ACK waits for ack_in forever.
module tcp_seg_tx
    import tcp_pkg::*;
#(
    parameter logic [31:0] ISN        = 32'h0000_1000,
    parameter logic [15:0] SRC_PORT   = 16'h1234,
    parameter logic [15:0] DST_PORT   = 16'h0050,
    parameter int unsigned RTO_CYCLES = 64,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    tcp_seg_tx_if.slave   io_seg
);

    localparam logic [31:0] SEQ_ACKED = ISN + 32'd1;

    tx_state_e              r_state;
    logic [TCP_IDX_W-1:0]   r_idx;
    seg_type_e              r_type;
    logic [31:0]            r_ack_num;
    logic [31:0]            r_seq_num;
    logic                   r_tx_valid;
    logic [7:0]             r_tx_data;
    logic                   r_tx_last;
    logic                   r_busy;
    logic                   r_timeout;

    tx_state_e              w_nxt_state;
    logic [TCP_IDX_W-1:0]   w_nxt_idx;
    seg_type_e              w_nxt_type;
    logic [31:0]            w_nxt_ack;
    logic [31:0]            w_nxt_seq;
    logic                   w_nxt_valid;
    logic [7:0]             w_nxt_data;
    logic                   w_nxt_last;
    logic                   w_nxt_timeout;
    tcp_hdr_t               w_nxt_hdr;
    logic                   w_retry_clr;
    logic                   w_retry_inc;
    logic                   w_expire;
    logic                   w_exhausted;

`ifdef TCP_TX_RETX_EN
    tcp_retx_timer #(
        .RTO_CYCLES (RTO_CYCLES),
        .MAX_RETRY  (MAX_RETRY)
    ) u_retx_timer (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_run         (r_state == ST_WAIT_ACK),
        .i_retry_clr   (w_retry_clr),
        .i_retry_inc   (w_retry_inc),
        .o_expire_c    (w_expire),
        .o_exhausted_c (w_exhausted)
    );

    assign io_seg.timeout = r_timeout;
`else
    assign w_expire       = 1'b0;
    assign w_exhausted    = 1'b0;
    assign io_seg.timeout = 1'b0;

    logic w_unused_cfg;
    assign w_unused_cfg = ^{w_retry_clr, w_retry_inc, r_timeout,
                            32'(RTO_CYCLES), 32'(MAX_RETRY)};
`endif

    assign io_seg.tx_valid = r_tx_valid;
    assign io_seg.tx_data  = r_tx_data;
    assign io_seg.tx_last  = r_tx_last;
    assign io_seg.busy     = r_busy;
    assign io_seg.seq_num  = r_seq_num;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Next state, latched segment fields and next stream outputs.
    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_idx     = r_idx;
        w_nxt_type    = r_type;
        w_nxt_ack     = r_ack_num;
        w_nxt_seq     = r_seq_num;
        w_nxt_timeout = 1'b0;
        w_retry_clr   = 1'b0;
        w_retry_inc   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (io_seg.send_syn || io_seg.send_synack || io_seg.send_ack) begin
                    w_nxt_state = ST_SEND;
                    w_nxt_idx   = '0;
                    w_retry_clr = 1'b1;
                    if (io_seg.send_syn) begin
                        w_nxt_type = SEG_SYN;
                        w_nxt_ack  = '0;
                    end else if (io_seg.send_synack) begin
                        w_nxt_type = SEG_SYNACK;
                        w_nxt_ack  = io_seg.rx_seq + 32'd1;
                    end else begin
                        w_nxt_type = SEG_ACK;
                        w_nxt_ack  = io_seg.rx_seq + 32'd1;
                    end
                end
            end
            ST_SEND: begin
                if (r_tx_valid && io_seg.tx_ready) begin
                    if (r_idx == TCP_LAST_IDX) begin
                        w_nxt_state = (r_type == SEG_ACK) ? ST_IDLE : ST_WAIT_ACK;
                    end else begin
                        w_nxt_idx = r_idx + TCP_IDX_W'(1);
                    end
                end
            end
            ST_WAIT_ACK: begin
                // An ack arriving together with expiry takes precedence.
                if (io_seg.ack_in) begin
                    w_nxt_seq   = SEQ_ACKED;
                    w_nxt_state = ST_IDLE;
                end else if (w_expire) begin
                    if (w_exhausted) begin
                        w_nxt_timeout = 1'b1;
                        w_nxt_state   = ST_IDLE;
                    end else begin
                        w_retry_inc = 1'b1;
                        w_nxt_state = ST_SEND;
                        w_nxt_idx   = '0;
                    end
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase

        w_nxt_hdr.src_port = SRC_PORT;
        w_nxt_hdr.dst_port = DST_PORT;
        w_nxt_hdr.seq      = (w_nxt_type == SEG_ACK) ? SEQ_ACKED : ISN;
        w_nxt_hdr.ack      = w_nxt_ack;
        w_nxt_hdr.flags    = seg_flags(w_nxt_type);

        // Outputs follow the registered index, so they hold while stalled.
        w_nxt_valid = (w_nxt_state == ST_SEND);
        w_nxt_data  = w_nxt_valid ? hdr_byte(w_nxt_hdr, w_nxt_idx) : 8'h00;
        w_nxt_last  = w_nxt_valid && (w_nxt_idx == TCP_LAST_IDX);
    end

    // Datapath and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idx      <= '0;
            r_type     <= SEG_SYN;
            r_ack_num  <= '0;
            r_seq_num  <= ISN;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
            r_tx_last  <= 1'b0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_idx      <= w_nxt_idx;
            r_type     <= w_nxt_type;
            r_ack_num  <= w_nxt_ack;
            r_seq_num  <= w_nxt_seq;
            r_tx_valid <= w_nxt_valid;
            r_tx_data  <= w_nxt_data;
            r_tx_last  <= w_nxt_last;
            r_busy     <= (w_nxt_state != ST_IDLE);
            r_timeout  <= w_nxt_timeout;
        end
    end

endmodule

// File: tb/tb_tcp_seg_tx.sv
// Directed + randomized bench for tcp_seg_tx with a header-level reference
// model. Retransmission checks follow the TCP_TX_RETX_EN build option.
module tb_tcp_seg_tx;

    localparam logic [31:0] ISN      = 32'h0000_1000;
    localparam logic [15:0] SRC      = 16'h1234;
    localparam logic [15:0] DST      = 16'h0050;
    localparam int          RTO      = 64;
    localparam int          MAXR     = 3;

    typedef logic [7:0] seg_t [13];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tcp_seg_tx_if bus ();

    tcp_seg_tx dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_seg (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_seq;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference header: kind 0=SYN, 1=SYN-ACK, 2=ACK.
    function automatic void build_seg(input int kind, input logic [31:0] rx, output seg_t b);
        logic [31:0] s;
        logic [31:0] a;
        s = (kind == 2) ? ISN + 32'd1 : ISN;
        a = (kind == 0) ? 32'd0 : rx + 32'd1;
        b[0] = 8'(SRC >> 8);
        b[1] = 8'(SRC);
        b[2] = 8'(DST >> 8);
        b[3] = 8'(DST);
        for (int i = 0; i < 4; i++) begin
            b[4 + i] = 8'(s >> (24 - 8 * i));
            b[8 + i] = 8'(a >> (24 - 8 * i));
        end
        b[12] = (kind == 0) ? 8'h02 : (kind == 1) ? 8'h12 : 8'h10;
    endfunction

    task automatic req(input bit syn, input bit synack, input bit ack, input logic [31:0] rx);
        @(negedge clk);
        bus.send_syn    = syn;
        bus.send_synack = synack;
        bus.send_ack    = ack;
        bus.rx_seq      = rx;
        bus.tx_ready    = 1'b0;
        @(negedge clk);
        bus.send_syn    = 1'b0;
        bus.send_synack = 1'b0;
        bus.send_ack    = 1'b0;
        bus.rx_seq      = $urandom;
    endtask

    // Receives one segment with stall percentage 'stall'; returns cycles used.
    task automatic recv(input seg_t e, input int stall, input string tag, output int cyc);
        int k;
        bit stalled;
        logic [7:0] hd;
        logic hl;
        k = 0; cyc = 0; stalled = 1'b0; hd = 8'h00; hl = 1'b0;
        check($sformatf("%s_first_valid", tag), 32'(bus.tx_valid), 32'd1);
        while (k < 13 && cyc < 2000) begin
            if (k > 0) check($sformatf("%s_valid_held", tag), 32'(bus.tx_valid), 32'd1);
            if (stalled) begin
                check($sformatf("%s_stall_data", tag), 32'(bus.tx_data), 32'(hd));
                check($sformatf("%s_stall_last", tag), 32'(bus.tx_last), 32'(hl));
            end
            bus.tx_ready = (int'($urandom_range(99)) >= stall);
            if (bus.tx_valid && bus.tx_ready) begin
                check($sformatf("%s_byte%0d", tag, k), 32'(bus.tx_data), 32'(e[k]));
                check($sformatf("%s_last%0d", tag, k), 32'(bus.tx_last), 32'(k == 12));
                k++;
                stalled = 1'b0;
            end else begin
                stalled = bus.tx_valid;
                hd = bus.tx_data;
                hl = bus.tx_last;
            end
            @(negedge clk);
            cyc++;
        end
        check($sformatf("%s_complete", tag), 32'(k), 32'd13);
        check($sformatf("%s_valid_fall", tag), 32'(bus.tx_valid), 32'd0);
        bus.tx_ready = 1'b0;
    endtask

    task automatic do_ack(input string tag);
        @(negedge clk);
        bus.ack_in = 1'b1;
        @(negedge clk);
        bus.ack_in = 1'b0;
        exp_seq = ISN + 32'd1;
        check($sformatf("%s_busy", tag), 32'(bus.busy), 32'd0);
        check($sformatf("%s_seq", tag), bus.seq_num, exp_seq);
    endtask

    initial begin
        seg_t e;
        int cyc;
        int gap;
        int bad;
        int kind;
        logic [2:0] r;
        logic [31:0] rx;

        rst = 1'b1;
        bus.send_syn = 1'b0; bus.send_synack = 1'b0; bus.send_ack = 1'b0;
        bus.rx_seq = 32'd0; bus.ack_in = 1'b0; bus.tx_ready = 1'b0;
        exp_seq = ISN;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_last", 32'(bus.tx_last), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_timeout", 32'(bus.timeout), 32'd0);
        check("rst_data", 32'(bus.tx_data), 32'd0);
        check("rst_seq", bus.seq_num, ISN);
        rst = 1'b0;

        // ack_in while idle has no effect
        @(negedge clk); bus.ack_in = 1'b1;
        @(negedge clk); bus.ack_in = 1'b0;
        @(negedge clk);
        check("idle_ack_seq", bus.seq_num, ISN);
        check("idle_ack_busy", 32'(bus.busy), 32'd0);

        // SYN, sink always ready: 13 back-to-back bytes
        build_seg(0, 32'd0, e);
        req(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
        recv(e, 0, "syn", cyc);
        check("syn_cycles", 32'(cyc), 32'd13);
        repeat (10) @(negedge clk);
        check("syn_busy_wait", 32'(bus.busy), 32'd1);
        check("syn_seq_wait", bus.seq_num, ISN);
        do_ack("syn_ack");

        // SYN-ACK with rx_seq wrap-around
        build_seg(1, 32'hFFFF_FFFF, e);
        req(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);
        recv(e, 0, "synack_wrap", cyc);
        do_ack("synack_ack");

        // SYN with a stalling sink
        build_seg(0, 32'd0, e);
        req(1'b1, 1'b0, 1'b0, 32'd0);
        recv(e, 50, "syn_stall", cyc);
        do_ack("syn_stall_ack");

        // Random requests, coincident pulses, stalls
        for (int it = 0; it < 10; it++) begin
            r  = 3'($urandom_range(1, 7));
            rx = $urandom;
            kind = r[0] ? 0 : r[1] ? 1 : 2;
            build_seg(kind, rx, e);
            req(r[0], r[1], r[2], rx);
            recv(e, 40, $sformatf("rnd%0d", it), cyc);
            if (kind == 2) begin
                check($sformatf("rnd%0d_ack_idle", it), 32'(bus.busy), 32'd0);
                check($sformatf("rnd%0d_ack_seq", it), bus.seq_num, exp_seq);
            end else begin
                check($sformatf("rnd%0d_busy", it), 32'(bus.busy), 32'd1);
                req(1'b1, 1'b1, 1'b1, $urandom);
                bad = 0;
                repeat ($urandom_range(1, 30)) begin
                    @(negedge clk);
                    if (bus.tx_valid !== 1'b0) bad++;
                end
                check($sformatf("rnd%0d_busy_req_ignored", it), 32'(bad), 32'd0);
                do_ack($sformatf("rnd%0d_ackin", it));
            end
        end

`ifdef TCP_TX_RETX_EN
        // Unacknowledged SYN: MAX_RETRY resends, then a timeout pulse
        build_seg(0, 32'd0, e);
        req(1'b1, 1'b0, 1'b0, 32'd0);
        recv(e, 30, "retx0", cyc);
        for (int n = 1; n <= MAXR; n++) begin
            gap = 0;
            while (!bus.tx_valid && gap < 1000) begin
                @(negedge clk);
                gap++;
            end
            check($sformatf("retx%0d_gap", n), 32'(gap), 32'(RTO));
            recv(e, 30, $sformatf("retx%0d", n), cyc);
        end
        bad = 0;
        for (int j = 1; j <= RTO; j++) begin
            @(negedge clk);
            if (j < RTO && (bus.tx_valid !== 1'b0 || bus.timeout !== 1'b0)) bad++;
        end
        check("to_quiet", 32'(bad), 32'd0);
        check("to_pulse", 32'(bus.timeout), 32'd1);
        check("to_busy", 32'(bus.busy), 32'd0);
        check("to_valid", 32'(bus.tx_valid), 32'd0);
        @(negedge clk);
        check("to_pulse_end", 32'(bus.timeout), 32'd0);
        check("to_busy_end", 32'(bus.busy), 32'd0);
        check("to_seq", bus.seq_num, exp_seq);
`else
        // Without retransmission the wait for ack_in never ends
        build_seg(0, 32'd0, e);
        req(1'b1, 1'b0, 1'b0, 32'd0);
        recv(e, 30, "noretx", cyc);
        bad = 0;
        repeat (4 * RTO) begin
            @(negedge clk);
            if (bus.tx_valid !== 1'b0 || bus.timeout !== 1'b0) bad++;
        end
        check("noretx_quiet", 32'(bad), 32'd0);
        check("noretx_busy", 32'(bus.busy), 32'd1);
        do_ack("noretx_ack");
`endif

        // ack_in exactly at timer expiry: ack wins
        build_seg(0, 32'd0, e);
        req(1'b1, 1'b0, 1'b0, 32'd0);
        recv(e, 0, "exp", cyc);
        repeat (RTO - 1) @(negedge clk);
        bus.ack_in = 1'b1;
        @(negedge clk);
        bus.ack_in = 1'b0;
        exp_seq = ISN + 32'd1;
        check("exp_busy", 32'(bus.busy), 32'd0);
        check("exp_valid", 32'(bus.tx_valid), 32'd0);
        check("exp_timeout", 32'(bus.timeout), 32'd0);
        check("exp_seq", bus.seq_num, 32'h0000_1001);
        bad = 0;
        repeat (RTO + 8) begin
            @(negedge clk);
            if (bus.tx_valid !== 1'b0 || bus.timeout !== 1'b0) bad++;
        end
        check("exp_quiet", 32'(bad), 32'd0);
        rx = $urandom;
        build_seg(2, rx, e);
        req(1'b0, 1'b0, 1'b1, rx);
        recv(e, 20, "exp_ack_seg", cyc);

        // Reset in the middle of a SYN
        build_seg(0, 32'd0, e);
        req(1'b1, 1'b0, 1'b0, 32'd0);
        bus.tx_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("rstmid_byte6", 32'(bus.tx_data), 32'(e[6]));
        rst = 1'b1;
        bus.tx_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_seq = ISN;
        check("rstmid_valid", 32'(bus.tx_valid), 32'd0);
        check("rstmid_busy", 32'(bus.busy), 32'd0);
        check("rstmid_seq", bus.seq_num, ISN);
        req(1'b1, 1'b0, 1'b0, 32'd0);
        recv(e, 30, "rstmid_restart", cyc);
        do_ack("rstmid_ack");

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
